tol_stream_checker: RTL and testbench

Synthesizable, parametrised multi-lane tolerance checker for the FAS verification flow. It compares DUT output beats against a golden ROM with a per-sample absolute tolerance, counts failing samples, captures the first mismatch, aborts at a fail limit and reports per-window and final pass/fail. It generalises the FIR (1 lane, ±1) and FFT (16 lanes × re/im, ±3) checks into one block usable on FPGA prototypes and in the FAS bench.

---
 rtl/tol_stream_checker_if.sv | 38 +++
 rtl/tol_stream_checker.sv | 241 ++++++++++++++++++++++++
 tb/tb_tol_stream_checker.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/tol_stream_checker_if.sv
// tol_stream_checker_if
// Beat stream plus golden-ROM read port seen by tol_stream_checker.
//   in_valid / in_data / lane_mask : DUT beat under test (lane n at [n*DATA_W +: DATA_W])
//   gold_rd_en / gold_addr         : golden ROM read request (issued by the checker)
//   gold_data                      : ROM read data, valid one cycle after gold_rd_en
// master = beat source + ROM side, slave = checker side.
interface tol_stream_checker_if #(
    parameter int DATA_W = 16,
    parameter int LANES  = 16,
    parameter int DEPTH  = 1024
);
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic                    in_valid;
    logic [LANES*DATA_W-1:0] in_data;
    logic [LANES-1:0]        lane_mask;
    logic                    gold_rd_en;
    logic [ADDR_W-1:0]       gold_addr;
    logic [LANES*DATA_W-1:0] gold_data;

    modport master (
        output in_valid,
        output in_data,
        output lane_mask,
        output gold_data,
        input  gold_rd_en,
        input  gold_addr
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  lane_mask,
        input  gold_data,
        output gold_rd_en,
        output gold_addr
    );
endinterface

// File: rtl/tol_stream_checker.sv
// tol_stream_checker
// Multi-lane tolerance checker: compares each accepted DUT beat against a golden
// ROM beat, lane by lane, with an absolute tolerance. Counts failing samples
// (saturating), captures the first mismatch, reports per-window pass/fail,
// aborts once the fail limit is reached and reports final done/pass.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   bus (slave)       beat stream in, golden ROM read port out
//   beat_cnt          beats accepted
//   err_cnt           failing samples, saturating
//   win_pulse/win_ok  one pulse per WINDOW checked beats; win_ok = window clean
//   first_err_*       sticky capture of the first failing beat / lowest lane
//   fail, done, pass  sticky run status
//
// Pipeline: stage 1 registers the beat while the ROM read is in flight,
// stage 2 registers the per-lane fail mask, stage 3 updates the counters.
//
// state | meaning
// ------+-------------------------------------------------------------
// RUN   | accepting beats, ROM reads issued with each accepted beat
// DRAIN | all DEPTH beats accepted, waiting for pipeline to empty
// DONE  | run complete, pass/done final, terminal until rst
// ABORT | fail limit reached, pipeline drains, done after two cycles
module tol_stream_checker #(
    parameter  int DATA_W     = 16,
    parameter  int LANES      = 16,
    parameter  int TOL        = 3,
    parameter  int DEPTH      = 1024,
    parameter  int WINDOW     = 16,
    parameter  int FAIL_LIMIT = 48,
    parameter  int CNT_W      = 16,
    localparam int ADDR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int LANE_W     = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    tol_stream_checker_if.slave    bus,
    output logic [ADDR_W:0]        beat_cnt,
    output logic [CNT_W-1:0]       err_cnt,
    output logic                   win_pulse,
    output logic                   win_ok,
    output logic                   first_err_valid,
    output logic [ADDR_W-1:0]      first_err_beat,
    output logic [LANE_W-1:0]      first_err_lane,
    output logic                   fail,
    output logic                   done,
    output logic                   pass
);
    localparam int BC_W  = ADDR_W + 1;
    localparam int POP_W = $clog2(LANES + 1);
    localparam int WIN_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;

    localparam logic [DATA_W:0]   TOL_V    = (DATA_W + 1)'(TOL);
    localparam logic [CNT_W:0]    LIMIT_V  = (CNT_W + 1)'(FAIL_LIMIT);
    localparam logic [WIN_W-1:0]  WIN_LOAD = WIN_W'(WINDOW - 1);
    localparam logic [BC_W-1:0]   LAST_BEAT = BC_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2,
        ST_ABORT = 2'd3
    } state_t;

    state_t state, state_nxt;

    // stage 1: beat waiting for its golden data
    logic                    s1_valid;
    logic [LANES*DATA_W-1:0] s1_data;
    logic [LANES-1:0]        s1_mask;
    logic [ADDR_W-1:0]       s1_beat;

    // stage 2: per-lane fail mask
    logic                    s2_valid;
    logic [LANES-1:0]        s2_fail;
    logic [ADDR_W-1:0]       s2_beat;

    logic [LANES-1:0]        lane_fail;
    logic [DATA_W:0]         samp_ext, gold_ext, diff, mag;
    logic [POP_W-1:0]        pop;
    logic [LANE_W-1:0]       low_lane;
    logic [CNT_W:0]          err_sum;
    logic [CNT_W-1:0]        err_nxt;
    logic                    abort_now;
    logic                    accept;

    logic [WIN_W-1:0]        win_tmr;
    logic                    win_flag;
    logic                    abort_tmr;

    // Sign-extend both operands by one bit so the difference cannot wrap;
    // |diff| tops out at 2^DATA_W-1 and still fits.
    always_comb begin
        lane_fail = '0;
        samp_ext  = '0;
        gold_ext  = '0;
        diff      = '0;
        mag       = '0;
        for (int n = 0; n < LANES; n++) begin
            samp_ext = {s1_data[n*DATA_W + DATA_W - 1], s1_data[n*DATA_W +: DATA_W]};
            gold_ext = {bus.gold_data[n*DATA_W + DATA_W - 1], bus.gold_data[n*DATA_W +: DATA_W]};
            diff     = samp_ext - gold_ext;
            mag      = diff[DATA_W] ? (~diff + (DATA_W + 1)'(1)) : diff;
            lane_fail[n] = s1_mask[n] && (mag > TOL_V);
        end
    end

    // Stage-3 arithmetic: failing-sample count, lowest failing lane,
    // saturating error count and the abort decision for this cycle.
    always_comb begin
        pop      = '0;
        low_lane = '0;
        for (int n = 0; n < LANES; n++) begin
            pop = pop + POP_W'(s2_fail[n]);
        end
        for (int n = LANES - 1; n >= 0; n--) begin
            if (s2_fail[n]) begin
                low_lane = LANE_W'(n);
            end
        end
        err_sum   = {1'b0, err_cnt} + (CNT_W + 1)'(pop);
        err_nxt   = err_sum[CNT_W] ? {CNT_W{1'b1}} : err_sum[CNT_W-1:0];
        abort_now = s2_valid && !fail
                    && ((state == ST_RUN) || (state == ST_DRAIN))
                    && ({1'b0, err_nxt} >= LIMIT_V);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // A limit crossing in this cycle blocks acceptance in the same cycle,
    // so no ROM read is issued once the run is known to abort.
    always_comb begin
        state_nxt      = state;
        accept         = 1'b0;
        bus.gold_rd_en = 1'b0;
        bus.gold_addr  = beat_cnt[ADDR_W-1:0];
        case (state)
            ST_RUN: begin
                accept         = bus.in_valid && !abort_now;
                bus.gold_rd_en = accept;
                if (abort_now) begin
                    state_nxt = ST_ABORT;
                end else if (accept && (beat_cnt == LAST_BEAT)) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (abort_now) begin
                    state_nxt = ST_ABORT;
                end else if (!s1_valid && !s2_valid) begin
                    state_nxt = ST_DONE;
                end
            end
            default: begin
                state_nxt = state;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid        <= 1'b0;
            s1_data         <= '0;
            s1_mask         <= '0;
            s1_beat         <= '0;
            s2_valid        <= 1'b0;
            s2_fail         <= '0;
            s2_beat         <= '0;
            beat_cnt        <= '0;
            err_cnt         <= '0;
            win_pulse       <= 1'b0;
            win_ok          <= 1'b0;
            win_flag        <= 1'b0;
            win_tmr         <= WIN_LOAD;
            first_err_valid <= 1'b0;
            first_err_beat  <= '0;
            first_err_lane  <= '0;
            fail            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            abort_tmr       <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_data  <= bus.in_data;
                s1_mask  <= bus.lane_mask;
                s1_beat  <= beat_cnt[ADDR_W-1:0];
                beat_cnt <= beat_cnt + BC_W'(1);
            end

            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_fail <= lane_fail;
                s2_beat <= s1_beat;
            end

            win_pulse <= 1'b0;
            if (s2_valid) begin
                err_cnt <= err_nxt;
                if ((|s2_fail) && !first_err_valid) begin
                    first_err_valid <= 1'b1;
                    first_err_beat  <= s2_beat;
                    first_err_lane  <= low_lane;
                end
                // The WINDOW-th beat closes its own window; the flag restarts clean.
                if (win_tmr == '0) begin
                    win_pulse <= 1'b1;
                    win_ok    <= !(win_flag || (|s2_fail));
                    win_flag  <= 1'b0;
                    win_tmr   <= WIN_LOAD;
                end else begin
                    win_flag  <= win_flag || (|s2_fail);
                    win_tmr   <= win_tmr - WIN_W'(1);
                end
            end

            if (abort_now) begin
                fail      <= 1'b1;
                abort_tmr <= 1'b1;
            end else if (state == ST_ABORT) begin
                if (abort_tmr != 1'b0) begin
                    abort_tmr <= 1'b0;
                end else begin
                    done <= 1'b1;
                end
            end

            if ((state == ST_DRAIN) && (state_nxt == ST_DONE)) begin
                done <= 1'b1;
                pass <= (err_cnt == '0);
            end
        end
    end
endmodule

// File: tb/tb_tol_stream_checker.sv
module tb_tol_stream_checker;
    localparam int DATA_W     = 16;
    localparam int LANES      = 16;
    localparam int TOL        = 3;
    localparam int DEPTH      = 32;
    localparam int WINDOW     = 8;
    localparam int FAIL_LIMIT = 48;
    localparam int CNT_W      = 6;
    localparam int ADDR_W     = $clog2(DEPTH);
    localparam int LANE_W     = $clog2(LANES);
    localparam int DW         = LANES * DATA_W;
    localparam int SAT        = (1 << CNT_W) - 1;
    localparam int HIST       = 8192;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tol_stream_checker_if #(.DATA_W(DATA_W), .LANES(LANES), .DEPTH(DEPTH)) bus ();

    logic [ADDR_W:0]   beat_cnt;
    logic [CNT_W-1:0]  err_cnt;
    logic              win_pulse, win_ok, first_err_valid, fail, done, pass;
    logic [ADDR_W-1:0] first_err_beat;
    logic [LANE_W-1:0] first_err_lane;

    tol_stream_checker #(
        .DATA_W(DATA_W), .LANES(LANES), .TOL(TOL), .DEPTH(DEPTH),
        .WINDOW(WINDOW), .FAIL_LIMIT(FAIL_LIMIT), .CNT_W(CNT_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus),
        .beat_cnt        (beat_cnt),
        .err_cnt         (err_cnt),
        .win_pulse       (win_pulse),
        .win_ok          (win_ok),
        .first_err_valid (first_err_valid),
        .first_err_beat  (first_err_beat),
        .first_err_lane  (first_err_lane),
        .fail            (fail),
        .done            (done),
        .pass            (pass)
    );

    logic [DW-1:0]    gold_mem [DEPTH];
    logic [DW-1:0]    dut_mem  [DEPTH];
    logic [LANES-1:0] mask_mem [DEPTH];
    int               gap_mem  [DEPTH];
    int               c_mem    [DEPTH];

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // golden ROM: one-cycle read latency
    always @(posedge clk) begin
        if (bus.gold_rd_en) bus.gold_data <= gold_mem[bus.gold_addr];
    end

    int done_cyc = -1;
    bit win_q[$];
    int err_hist[HIST];

    always @(negedge clk) begin
        if (rst) begin
            done_cyc = -1;
            win_q.delete();
        end else begin
            if (cyc < HIST) err_hist[cyc] = int'(err_cnt);
            if (win_pulse) win_q.push_back(win_ok);
            if (done && done_cyc < 0) done_cyc = cyc;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int lane_val(logic [DW-1:0] v, int n);
        logic signed [DATA_W-1:0] s;
        s = v[n*DATA_W +: DATA_W];
        return int'(s);
    endfunction

    function automatic int sat(int v);
        return (v > SAT) ? SAT : v;
    endfunction

    // kind: 0 clean (in-tolerance noise), 1 two +-4 errors at beat 5,
    // 2 0x7FFF vs 0x8000, 3 all wrong back-to-back, 4 mask lane 0 only,
    // 5 sparse random errors/masks, 6 dense random errors with gaps
    task automatic gen(int kind);
        int g, d, mag;
        for (int i = 0; i < DEPTH; i++) begin
            mask_mem[i] = (kind == 4) ? LANES'(1) : ((kind == 5) ? LANES'($urandom) : '1);
            gap_mem[i]  = (kind == 3) ? 0 : int'($urandom_range(0, 2));
            for (int n = 0; n < LANES; n++) begin
                g = int'($urandom_range(0, 60000)) - 30000;
                d = g + int'($urandom_range(0, 2 * TOL)) - TOL;
                mag = TOL + 1 + int'($urandom_range(0, 20));
                if ($urandom_range(0, 1) == 0) mag = -mag;
                case (kind)
                    3: d = g + 100;
                    4: if (n != 0) d = g + 50;
                    5: if ($urandom_range(0, 63) == 0) d = g + mag;
                    6: if ($urandom_range(0, 7) == 0) d = g + mag;
                    default: ;
                endcase
                if (kind == 1 && i == 5 && n == 9)  d = g + 4;
                if (kind == 1 && i == 5 && n == 12) d = g - 4;
                if (kind == 2 && i == 10 && n == 3) begin
                    g = -32768;
                    d = 32767;
                end
                gold_mem[i][n*DATA_W +: DATA_W] = DATA_W'(g);
                dut_mem[i][n*DATA_W +: DATA_W]  = DATA_W'(d);
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drive_beats(int n_beats);
        for (int i = 0; i < n_beats; i++) begin
            repeat (gap_mem[i]) begin
                @(negedge clk);
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            bus.in_valid  = 1'b1;
            bus.in_data   = dut_mem[i];
            bus.lane_mask = mask_mem[i];
            c_mem[i]      = cyc + 1;
        end
    endtask

    task automatic run(string name);
        int fc[DEPTH];
        int fl[DEPTH];
        int abort_edge, acc, cum, first, flane, wcnt, exp_done, pre4, pre5;
        bit wbad, aborted;
        bit exp_win[$];

        do_reset();
        drive_beats(DEPTH);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = dut_mem[k];
            #1 check($sformatf("%s rd_en_after_end%0d", name, k), bus.gold_rd_en, 0);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int k = 0; k < 60 && !done; k++) @(negedge clk);
        repeat (2) @(negedge clk);

        // reference: per-beat failing samples from plain integer differences
        for (int i = 0; i < DEPTH; i++) begin
            fc[i] = 0;
            fl[i] = -1;
            for (int n = 0; n < LANES; n++) begin
                int df;
                df = lane_val(dut_mem[i], n) - lane_val(gold_mem[i], n);
                if (df < 0) df = -df;
                if (mask_mem[i][n] && df > TOL) begin
                    fc[i]++;
                    if (fl[i] < 0) fl[i] = n;
                end
            end
        end
        abort_edge = 1 << 30;
        acc = 0; cum = 0; first = -1; flane = 0; wcnt = 0; wbad = 0;
        pre4 = 0; pre5 = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (c_mem[i] >= abort_edge) break;
            acc++;
            cum += fc[i];
            if (i == 4) pre4 = cum;
            if (i == 5) pre5 = cum;
            if (fc[i] > 0 && first < 0) begin
                first = i;
                flane = fl[i];
            end
            wbad = wbad | (fc[i] > 0);
            wcnt++;
            if (wcnt == WINDOW) begin
                exp_win.push_back(!wbad);
                wcnt = 0;
                wbad = 0;
            end
            if (cum >= FAIL_LIMIT && abort_edge == (1 << 30)) abort_edge = c_mem[i] + 2;
        end
        aborted  = (abort_edge != (1 << 30));
        exp_done = aborted ? abort_edge + 2 : c_mem[DEPTH-1] + 3;

        check({name, " beat_cnt"}, beat_cnt, acc);
        check({name, " err_cnt"}, err_cnt, sat(cum));
        check({name, " fail"}, fail, aborted);
        check({name, " pass"}, pass, (!aborted && cum == 0));
        check({name, " done"}, done, 1);
        check({name, " done_cycle"}, done_cyc, exp_done);
        check({name, " first_err_valid"}, first_err_valid, (first >= 0));
        check({name, " first_err_beat"}, first_err_beat, (first >= 0) ? first : 0);
        check({name, " first_err_lane"}, first_err_lane, (first >= 0) ? flane : 0);
        check({name, " win_count"}, win_q.size(), exp_win.size());
        for (int k = 0; k < exp_win.size() && k < win_q.size(); k++) begin
            check($sformatf("%s win_ok%0d", name, k), win_q[k], exp_win[k]);
        end
        if (acc > 5 && c_mem[5] + 2 < HIST) begin
            check({name, " err_cnt_t+1"}, err_hist[c_mem[5] + 1], sat(pre4));
            check({name, " err_cnt_t+2"}, err_hist[c_mem[5] + 2], sat(pre5));
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.lane_mask = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset beat_cnt", beat_cnt, 0);
        check("reset err_cnt", err_cnt, 0);
        check("reset flags", {done, pass, fail, first_err_valid, win_pulse, win_ok}, 0);
        check("reset first_err", {first_err_beat, first_err_lane}, 0);
        check("reset gold_rd_en", bus.gold_rd_en, 0);
        check("reset gold_addr", bus.gold_addr, 0);

        gen(0); run("clean");
        gen(1); run("two_err");
        gen(2); run("no_wrap");
        gen(3); run("all_wrong");
        gen(4); run("mask_lane0");
        for (int r = 0; r < 3; r++) begin
            gen(5); run($sformatf("rand_sparse%0d", r));
            gen(6); run($sformatf("rand_dense%0d", r));
        end

        // reset in the middle of a run
        gen(1);
        do_reset();
        drive_beats(20);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("midrun beat_cnt_before", beat_cnt, 20);
        #2 rst = 1'b1;
        #1;
        check("midrun rst beat_cnt", beat_cnt, 0);
        check("midrun rst err_cnt", err_cnt, 0);
        check("midrun rst flags", {done, pass, fail, first_err_valid, win_pulse, win_ok}, 0);
        check("midrun rst first_err", {first_err_beat, first_err_lane}, 0);
        check("midrun rst gold", {bus.gold_rd_en, bus.gold_addr}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        gen(0); run("rerun");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
